tx_frame_loader: RTL and testbench

Upstream feeder for the serial transmit pair. It accepts a stream of 4-bit nibbles over a valid/ready handshake and steers them, in order, into the transmitter's four data inputs (A, B, C, D) using one-cycle load strobes. After the fourth nibble it issues a one-cycle `transmit` pulse, then holds off new input for a fixed gap so the serial frame can finish. Its outputs connect one-to-one to the A..D, ld_A..ld_D and transmit inputs of the transmit/receive top.

---
 rtl/tx_frame_loader_pkg.sv | 22 ++
 rtl/tx_frame_loader_gap_counter.sv | 36 +++
 rtl/tx_frame_loader.sv | 124 ++++++++++++
 tb/tb_tx_frame_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_loader_pkg.sv
// Shared types and widths for the transmit frame loader.
// Pulled in by the top module and by its gap counter.
package tx_frame_loader_pkg;

    localparam int NIB_W     = 4;
    localparam int NUM_SLOTS = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Slot index to load-strobe pattern (0=A ... 3=D).
    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [1:0] idx);
        logic [NUM_SLOTS-1:0] one;
        one = {{(NUM_SLOTS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/tx_frame_loader_gap_counter.sv
// Loadable down-counter that times the hold-off gap after each frame.
// The done flag marks the cycle whose count is 1, i.e. the last gap cycle.
module gap_counter
    import tx_frame_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The count parks at zero once the gap has expired.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/tx_frame_loader.sv
// Collects four nibbles into slots A..D with one-cycle load strobes,
// fires a transmit pulse, then holds off input for GAP_CYCLES cycles.
module tx_frame_loader
    import tx_frame_loader_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NIB_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [NIB_W-1:0] A,
    output logic [NIB_W-1:0] B,
    output logic [NIB_W-1:0] C,
    output logic [NIB_W-1:0] D,
    output logic             ld_A,
    output logic             ld_B,
    output logic             ld_C,
    output logic             ld_D,
    output logic             transmit,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [NIB_W-1:0]     slot_q [NUM_SLOTS];
    logic [NIB_W-1:0]     slot_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] ld_q, ld_d;
    logic                 transmit_q, transmit_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     frames_q, frames_d;
    logic                 accept;
    logic                 gap_load;
    logic                 gap_done;

    gap_counter u_gap_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (CNT_W'(GAP_CYCLES)),
        .done     (gap_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept && idx_q == 2'd3) state_d = FIRE;
            FIRE:    state_d = WAIT;
            WAIT:    if (gap_done) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Ready is held low during reset so nothing is taken before the flops settle.
    always_comb begin
        in_ready = (state_q == LOAD) && !flush && !rst;
        accept   = in_valid && in_ready;
        gap_load = (state_q == FIRE);
    end

    // Flush only rewinds the slot index; loaded slots keep their data.
    always_comb begin
        idx_d      = idx_q;
        slot_d     = slot_q;
        ld_d       = '0;
        transmit_d = (state_q == FIRE);
        frames_d   = frames_q;
        busy_d     = (state_d != LOAD);
        if (transmit_d) begin
            frames_d = frames_q + CNT_W'(1);
        end
        if (state_q == LOAD) begin
            if (flush) begin
                idx_d = '0;
            end else if (accept) begin
                slot_d[idx_q] = in_data;
                ld_d          = slot_onehot(idx_q);
                idx_d         = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            slot_q     <= '{default: '0};
            ld_q       <= '0;
            transmit_q <= 1'b0;
            busy_q     <= 1'b0;
            frames_q   <= '0;
        end else begin
            idx_q      <= idx_d;
            slot_q     <= slot_d;
            ld_q       <= ld_d;
            transmit_q <= transmit_d;
            busy_q     <= busy_d;
            frames_q   <= frames_d;
        end
    end

    assign A           = slot_q[0];
    assign B           = slot_q[1];
    assign C           = slot_q[2];
    assign D           = slot_q[3];
    assign ld_A        = ld_q[0];
    assign ld_B        = ld_q[1];
    assign ld_C        = ld_q[2];
    assign ld_D        = ld_q[3];
    assign transmit    = transmit_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_tx_frame_loader.sv
// Self-checking bench for tx_frame_loader: vector tables, corner sequences
// and random traffic compared against a nibble-count / hold-off reference model.
module tb_tx_frame_loader;

    localparam int GAP = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid, flush, in_ready;
    logic [3:0] A, B, C, D;
    logic       ld_A, ld_B, ld_C, ld_D, transmit, busy;
    logic [7:0] frames_sent;

    logic [3:0] f_in_data;
    logic       f_in_valid, f_flush, f_in_ready;
    logic [3:0] f_A, f_B, f_C, f_D;
    logic       f_ld_A, f_ld_B, f_ld_C, f_ld_D, f_transmit, f_busy;
    logic [7:0] f_frames_sent;

    always #5 clk = ~clk;

    tx_frame_loader #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .A(A), .B(B), .C(C), .D(D),
        .ld_A(ld_A), .ld_B(ld_B), .ld_C(ld_C), .ld_D(ld_D),
        .transmit(transmit), .busy(busy), .frames_sent(frames_sent)
    );

    tx_frame_loader #(.GAP_CYCLES(1)) dut_fast (
        .clk(clk), .rst(rst), .in_data(f_in_data), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .flush(f_flush), .A(f_A), .B(f_B), .C(f_C), .D(f_D),
        .ld_A(f_ld_A), .ld_B(f_ld_B), .ld_C(f_ld_C), .ld_D(f_ld_D),
        .transmit(f_transmit), .busy(f_busy), .frames_sent(f_frames_sent)
    );

    typedef struct {
        bit         v;
        logic [3:0] d;
        bit         f;
        bit         exp_rdy;
        logic [3:0] exp_ld;
        bit         exp_tx;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   tx_seen = 0;

    // Reference model: nibbles collected so far, cycles of hold-off remaining.
    int         nibs;
    int         holdoff;
    bit         fire_pending;
    logic [3:0] m_slot [4];
    logic [3:0] m_ld;
    bit         m_tx;
    int         m_frames;
    bit         cur_v, cur_f;
    logic [3:0] cur_d;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        nibs = 0;
        holdoff = 0;
        fire_pending = 0;
        m_ld = '0;
        m_tx = 0;
        m_frames = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
    endfunction

    function automatic void model_step();
        bit loading;
        bit acc;
        loading = (holdoff == 0);
        acc = loading && !cur_f && cur_v;
        m_tx = fire_pending;
        fire_pending = 0;
        if (m_tx) m_frames = (m_frames + 1) % 256;
        if (holdoff > 0) holdoff--;
        m_ld = '0;
        if (acc) begin
            m_slot[nibs] = cur_d;
            m_ld[nibs] = 1'b1;
            nibs++;
            if (nibs == 4) begin
                nibs = 0;
                fire_pending = 1;
                holdoff = GAP + 1;
            end
        end else if (loading && cur_f) begin
            nibs = 0;
        end
    endfunction

    function automatic void add_vec(bit v, logic [3:0] d, bit f, bit r, logic [3:0] l, bit t);
        vec_t x;
        x.v = v; x.d = d; x.f = f; x.exp_rdy = r; x.exp_ld = l; x.exp_tx = t;
        vecs.push_back(x);
    endfunction

    task automatic applyStimulus(input bit v, input logic [3:0] d, input bit f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        cur_v = v; cur_d = d; cur_f = f;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'((holdoff == 0) && !f));
    endtask

    task automatic clockStep();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (transmit === 1'b1) tx_seen++;
        checkOutput("ld", 32'({ld_D, ld_C, ld_B, ld_A}), 32'(m_ld));
        checkOutput("transmit", 32'(transmit), 32'(m_tx));
        checkOutput("busy", 32'(busy), 32'(holdoff > 0));
        checkOutput("slots", 32'({A, B, C, D}), 32'({m_slot[0], m_slot[1], m_slot[2], m_slot[3]}));
        checkOutput("frames_sent", 32'(frames_sent), 32'(m_frames));
    endtask

    task automatic run_vec(input vec_t t);
        applyStimulus(t.v, t.d, t.f);
        checkOutput("vec_ready", 32'(in_ready), 32'(t.exp_rdy));
        clockStep();
        checkOutput("vec_ld", 32'({ld_D, ld_C, ld_B, ld_A}), 32'(t.exp_ld));
        checkOutput("vec_tx", 32'(transmit), 32'(t.exp_tx));
    endtask

    // Asserts reset between edges and checks the asynchronous clear.
    task automatic doReset();
        in_valid = 0; in_data = '0; flush = 0;
        cur_v = 0; cur_d = '0; cur_f = 0;
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_outputs",
            32'({in_ready, ld_D, ld_C, ld_B, ld_A, transmit, busy, A, B, C, D, frames_sent}), 32'd0);
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(in_ready), 32'd1);
        checkOutput("frames_after_reset", 32'(frames_sent), 32'd0);
        clockStep();
    endtask

    task automatic wait_transmit();
        for (int i = 0; i < 10; i++) begin
            if (transmit === 1'b1) break;
            applyStimulus(0, '0, 0);
            clockStep();
        end
        checkOutput("transmit_seen", 32'(transmit), 32'd1);
    endtask

    // Called in the transmit cycle; counts cycles until in_ready returns.
    task automatic measureGap(input bit with_flush);
        int gap_len;
        gap_len = -1;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(0, '0, with_flush && k >= 1 && k < 6);
            if (in_ready === 1'b1) begin
                gap_len = k;
                break;
            end
            clockStep();
        end
        checkOutput("gap_length", 32'(gap_len), 32'(GAP));
    endtask

    initial begin
        logic [3:0] stall_data [4];
        int accepted;
        int tx_before;
        int fast_tx;

        rst = 1'b1;
        in_valid = 0; in_data = '0; flush = 0;
        f_in_valid = 0; f_in_data = '0; f_flush = 0;
        model_reset();
        @(negedge clk);
        doReset();

        // Basic frame, then the flush sequence.
        add_vec(1, 4'h1, 0, 1, 4'b0001, 0);
        add_vec(1, 4'h2, 0, 1, 4'b0010, 0);
        add_vec(1, 4'h3, 0, 1, 4'b0100, 0);
        add_vec(1, 4'h4, 0, 1, 4'b1000, 0);
        add_vec(0, 4'h0, 0, 0, 4'b0000, 1);
        add_vec(1, 4'h5, 0, 1, 4'b0001, 0);
        add_vec(1, 4'h6, 0, 1, 4'b0010, 0);
        add_vec(0, 4'h0, 1, 0, 4'b0000, 0);
        add_vec(1, 4'hF, 1, 0, 4'b0000, 0);
        add_vec(1, 4'h7, 0, 1, 4'b0001, 0);
        add_vec(1, 4'h8, 0, 1, 4'b0010, 0);
        add_vec(1, 4'h9, 0, 1, 4'b0100, 0);
        add_vec(1, 4'hE, 0, 1, 4'b1000, 0);
        add_vec(0, 4'h0, 0, 0, 4'b0000, 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        checkOutput("basic_slots", 32'({A, B, C, D}), 32'h1234);
        checkOutput("basic_frames", 32'(frames_sent), 32'd1);
        measureGap(0);

        $display("[TB] producer stalls");
        stall_data = '{4'hA, 4'hB, 4'hC, 4'hD};
        accepted = 0;
        for (int i = 0; i < 200 && accepted < 4; i++) begin
            bit v;
            bit will_acc;
            v = 1'($urandom_range(0, 1));
            applyStimulus(v, stall_data[accepted], 0);
            will_acc = v && (holdoff == 0);
            clockStep();
            if (will_acc) begin
                checkOutput("stall_ld", 32'({ld_D, ld_C, ld_B, ld_A}), 32'd1 << accepted);
                accepted++;
            end else begin
                checkOutput("stall_no_ld", 32'({ld_D, ld_C, ld_B, ld_A}), 32'd0);
            end
        end
        checkOutput("stall_accepts", 32'(accepted), 32'd4);
        checkOutput("stall_slots", 32'({A, B, C, D}), 32'hABCD);
        wait_transmit();
        measureGap(0);

        $display("[TB] flush sequence");
        tx_before = tx_seen;
        for (int i = 5; i < vecs.size(); i++) run_vec(vecs[i]);
        measureGap(1);
        checkOutput("flush_slots", 32'({A, B, C, D}), 32'h789E);
        checkOutput("flush_tx_count", 32'(tx_seen - tx_before), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom % 4) != 0, 4'($urandom), ($urandom % 16) == 0);
            clockStep();
        end

        $display("[TB] mid-frame reset");
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'(i + 3), 0);
            clockStep();
        end
        doReset();
        tx_before = tx_seen;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, '0, 0);
            clockStep();
        end
        checkOutput("no_tx_after_reset", 32'(tx_seen - tx_before), 32'd0);
        applyStimulus(1, 4'hF, 0);
        clockStep();
        checkOutput("reload_from_A", 32'({ld_D, ld_C, ld_B, ld_A}), 32'b0001);
        applyStimulus(1, 4'hE, 0); clockStep();
        applyStimulus(1, 4'hD, 0); clockStep();
        applyStimulus(1, 4'hC, 0); clockStep();
        checkOutput("reload_slots", 32'({A, B, C, D}), 32'hFEDC);
        wait_transmit();
        measureGap(0);

        $display("[TB] frames_sent wrap");
        in_valid = 0; flush = 0;
        fast_tx = 0;
        f_in_valid = 1;
        for (int c = 0; c < 2000 && fast_tx < 256; c++) begin
            f_in_data = 4'(c);
            @(posedge clk);
            @(negedge clk);
            if (f_transmit === 1'b1) begin
                fast_tx++;
                checkOutput("wrap_count", 32'(f_frames_sent), 32'(fast_tx % 256));
            end
        end
        f_in_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (f_transmit === 1'b1) fast_tx++;
        end
        checkOutput("wrap_total", 32'(fast_tx), 32'd256);
        checkOutput("wrap_frames", 32'(f_frames_sent), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
